// File: rtl/fifo_arb_pkg.sv
// Shared types, defaults and the round-robin search used by the FIFO write arbiter
// and its picker.
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StGrant = 1'b1
    } arb_state_e;

    localparam int unsigned DefWidth    = 32;
    localparam int unsigned DefNReq     = 4;
    localparam int unsigned DefMaxBurst = 8;
    localparam int          MaxReq      = 16;

    // Returns the first requester strictly after `last` (wrapping mod n_req), or -1.
    // Descending loop so the nearest candidate is assigned last and wins.
    function automatic int rr_next(input logic [MaxReq-1:0] req,
                                   input logic [3:0]        last,
                                   input int                n_req);
        int         pick;
        int         idx;
        logic [3:0] idx4;
        pick = -1;
        for (int i = MaxReq; i >= 1; i--) begin
            if (i <= n_req) begin
                idx  = (int'(last) + i) % n_req;
                idx4 = 4'(idx);
                if (req[idx4]) begin
                    pick = idx;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: winner index and one-hot, searching upward
// from the entry after last_i.
module rr_priority_picker
    import fifo_arb_pkg::*;
#(
    parameter int unsigned N_REQ = DefNReq
) (
    input  logic [N_REQ-1:0]         req_i,
    input  logic [$clog2(N_REQ)-1:0] last_i,
    output logic                     valid_o,
    output logic [$clog2(N_REQ)-1:0] idx_o,
    output logic [N_REQ-1:0]         onehot_o
);

    localparam int unsigned IdW = $clog2(N_REQ);

    logic [MaxReq-1:0] req_pad;
    logic [3:0]        last_pad;
    int                pick;

    always_comb begin
        req_pad  = MaxReq'(req_i);
        last_pad = 4'(last_i);
        pick     = rr_next(req_pad, last_pad, int'(N_REQ));
        valid_o  = (pick >= 0);
        idx_o    = IdW'(pick);
        onehot_o = '0;
        if (valid_o) begin
            onehot_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ valid/ready producers,
// with bounded bursts and combinational back-pressure from the FIFO full flag.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned WIDTH     = DefWidth,
    parameter int unsigned N_REQ     = DefNReq,
    parameter int unsigned MAX_BURST = DefMaxBurst
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*WIDTH-1:0]   req_data,
    output logic [N_REQ-1:0]         req_ready,
    input  logic                     fifo_full,
    output logic                     fifo_w_enb,
    output logic [WIDTH-1:0]         fifo_d_in,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy
);

    localparam int unsigned IdW  = $clog2(N_REQ);
    localparam int unsigned CntW = $clog2(MAX_BURST) + 1;
    localparam logic [CntW-1:0] LastBeat = CntW'(MAX_BURST - 1);
    localparam logic [IdW-1:0]  LastReq  = IdW'(N_REQ - 1);

    arb_state_e       state_q, state_d;
    logic [IdW-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0] grant_oh_q, grant_oh_d;
    logic [IdW-1:0]   last_q, last_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic             pick_valid;
    logic [IdW-1:0]   pick_idx;
    logic [N_REQ-1:0] pick_oh;
    logic             sel_valid;

    rr_priority_picker #(
        .N_REQ (N_REQ)
    ) u_picker (
        .req_i    (req_valid),
        .last_i   (last_q),
        .valid_o  (pick_valid),
        .idx_o    (pick_idx),
        .onehot_o (pick_oh)
    );

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_oh_d = grant_oh_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        req_ready  = '0;
        fifo_w_enb = 1'b0;
        busy       = 1'b0;
        fifo_d_in  = '0;
        sel_valid  = 1'b0;

        for (int i = 0; i < int'(N_REQ); i++) begin
            if (grant_q == IdW'(i)) begin
                fifo_d_in = req_data[i*WIDTH +: WIDTH];
                sel_valid = req_valid[i];
            end
        end

        case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    state_d    = StGrant;
                    grant_d    = pick_idx;
                    grant_oh_d = pick_oh;
                    cnt_d      = '0;
                end
            end
            StGrant: begin
                busy       = 1'b1;
                req_ready  = fifo_full ? '0 : grant_oh_q;
                fifo_w_enb = sel_valid & ~fifo_full;
                if (fifo_w_enb) begin
                    cnt_d = cnt_q + CntW'(1);
                end
                // A full FIFO only stalls; release needs a finished burst or an idle producer.
                if ((fifo_w_enb && (cnt_q == LastBeat)) || (!sel_valid && !fifo_full)) begin
                    state_d = StIdle;
                    last_d  = grant_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            grant_q    <= '0;
            grant_oh_q <= '0;
            last_q     <= LastReq;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_oh_q <= grant_oh_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
        end
    end

    assign grant_id = grant_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter: producer and FIFO models, per-producer
// expected-word queues and an expected-grant queue checked by a monitor.
module tb_fifo_write_arbiter;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int MB = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic           fifo_full = 1'b0;
    logic           fifo_w_enb;
    logic [W-1:0]   fifo_d_in;
    logic [1:0]     grant_id;
    logic           busy;

    always #5 clk = ~clk;

    fifo_write_arbiter #(
        .WIDTH     (W),
        .N_REQ     (N),
        .MAX_BURST (MB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fifo_full  (fifo_full),
        .fifo_w_enb (fifo_w_enb),
        .fifo_d_in  (fifo_d_in),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Producer model: each word may be preceded by `gap` idle cycles.
    logic [W-1:0] src_q [N][$];
    int           gap_q [N][$];
    logic [W-1:0] exp_q [N][$];
    logic [N-1:0] fire = '0;

    typedef struct {
        int id;
        int beats;
        int cycles;
    } grant_t;
    grant_t exp_g[$];
    bit     chk_g = 1'b0;

    task automatic push_word(input int p, input logic [W-1:0] d, input int gap);
        src_q[p].push_back(d);
        gap_q[p].push_back(gap);
        exp_q[p].push_back(d);
    endtask

    task automatic push_grant(input int id, input int beats, input int cycles);
        grant_t g;
        g.id     = id;
        g.beats  = beats;
        g.cycles = cycles;
        exp_g.push_back(g);
    endtask

    always @(negedge clk) fire = req_valid & req_ready;

    always @(posedge clk) begin
        logic [N-1:0] v;
        #1;
        v = '0;
        for (int p = 0; p < N; p++) begin
            if (fire[p] && src_q[p].size() > 0) begin
                void'(src_q[p].pop_front());
                void'(gap_q[p].pop_front());
            end
            if (src_q[p].size() > 0) begin
                if (gap_q[p][0] > 0) begin
                    gap_q[p][0] = gap_q[p][0] - 1;
                end else begin
                    v[p] = 1'b1;
                    req_data[p*W +: W] = src_q[p][0];
                end
            end
        end
        req_valid = v;
    end

    // FIFO occupancy model; full follows the count updated at the write edge.
    int depth    = 4096;
    int fcnt     = 0;
    bit rd_force = 1'b0;
    bit rd_rand  = 1'b0;
    bit fifo_clr = 1'b0;

    always @(posedge clk) begin
        int n;
        n = fcnt;
        if (fifo_clr) begin
            n = 0;
        end else begin
            if (fifo_w_enb && !fifo_full) n++;
            if ((rd_force || (rd_rand && $urandom_range(0, 1) == 1)) && fcnt > 0) n--;
        end
        fcnt      <= n;
        fifo_full <= (n >= depth);
    end

    // Monitor: pops expected words on every write, expected grants on every release.
    int nwrites  = 0;
    bit busy_p   = 1'b0;
    int g_id     = 0;
    int g_beats  = 0;
    int g_cycles = 0;

    always @(negedge clk) begin
        grant_t e;
        if (busy && !busy_p) begin
            g_id     = int'(grant_id);
            g_beats  = 0;
            g_cycles = 0;
        end
        if (busy) g_cycles++;
        if (fifo_w_enb) begin
            nwrites++;
            g_beats++;
            check("write_while_full", longint'(fifo_full), 0);
            check("ready_onehot", longint'(req_ready), longint'(1) << grant_id);
            if (exp_q[grant_id].size() == 0) begin
                fail_now($sformatf("unexpected_write p%0d data %0h", grant_id, fifo_d_in));
            end else begin
                check($sformatf("data_p%0d", grant_id), longint'(fifo_d_in),
                      longint'(exp_q[grant_id][0]));
                void'(exp_q[grant_id].pop_front());
            end
        end
        if (!busy && busy_p && chk_g) begin
            if (exp_g.size() == 0) begin
                fail_now($sformatf("unexpected_grant id %0d", g_id));
            end else begin
                e = exp_g.pop_front();
                check("grant_id", g_id, e.id);
                check("grant_beats", g_beats, e.beats);
                if (e.cycles >= 0) check("grant_cycles", g_cycles, e.cycles);
            end
        end
        busy_p = busy;
    end

    task automatic do_reset(input int new_depth);
        reset    = 1'b0;
        fifo_clr = 1'b1;
        rd_rand  = 1'b0;
        rd_force = 1'b0;
        chk_g    = 1'b0;
        depth    = new_depth;
        for (int p = 0; p < N; p++) begin
            src_q[p].delete();
            gap_q[p].delete();
            exp_q[p].delete();
        end
        exp_g.delete();
        #1;
        check("rst_ready", longint'(req_ready), 0);
        check("rst_wenb", longint'(fifo_w_enb), 0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", longint'(busy), 0);
        check("rst_grant_id", longint'(grant_id), 0);
        #1;
        fifo_clr = 1'b0;
        reset    = 1'b1;
    endtask

    task automatic wait_idle(input int max_cycles, input string name);
        bit done;
        done = 1'b0;
        for (int c = 0; c < max_cycles && !done; c++) begin
            @(negedge clk);
            done = !busy && src_q[0].size() == 0 && src_q[1].size() == 0 &&
                   src_q[2].size() == 0 && src_q[3].size() == 0;
        end
        if (!done) fail_now({"timeout_", name});
        @(negedge clk);
        for (int p = 0; p < N; p++) begin
            check($sformatf("%s_leftover_p%0d", name, p), exp_q[p].size(), 0);
        end
        if (chk_g) check({name, "_leftover_grants"}, exp_g.size(), 0);
    endtask

    task automatic wait_writes(input int target, input int max_cycles, input string name);
        bit done;
        done = 1'b0;
        for (int c = 0; c < max_cycles && !done; c++) begin
            @(posedge clk);
            done = (nwrites >= target);
        end
        if (!done) fail_now({"timeout_", name});
    endtask

    initial begin
        int n0;

        // Single producer, 3 beats, release one cycle after valid drops.
        do_reset(4096);
        chk_g = 1'b1;
        push_grant(1, 3, 4);
        for (int i = 0; i < 3; i++) push_word(1, 32'hA0 + i, 0);
        wait_idle(100, "single");

        // Rotation with all four producers continuously valid.
        do_reset(4096);
        chk_g = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int p = 0; p < N; p++) push_grant(p, MB, MB);
        end
        for (int p = 0; p < N; p++) begin
            for (int i = 0; i < 2 * MB; i++) push_word(p, (p << 8) | i, 0);
        end
        n0 = nwrites;
        wait_idle(500, "rotation");
        check("rotation_writes", nwrites - n0, 8 * MB);

        // Full stall on a depth-4 FIFO.
        do_reset(4);
        chk_g = 1'b1;
        push_grant(2, 6, -1);
        n0 = nwrites;
        for (int i = 0; i < 6; i++) push_word(2, 32'h10 + i, 0);
        wait_writes(n0 + 4, 100, "full_fill");
        repeat (3) @(negedge clk);
        check("full_flag", longint'(fifo_full), 1);
        check("full_ready", longint'(req_ready), 0);
        check("full_wenb", longint'(fifo_w_enb), 0);
        check("full_busy", longint'(busy), 1);
        check("full_grant", longint'(grant_id), 2);
        check("full_writes", nwrites - n0, 4);
        @(posedge clk);
        #2 rd_force = 1'b1;
        @(posedge clk);
        #2 rd_force = 1'b0;
        repeat (4) @(negedge clk);
        check("onepop_writes", nwrites - n0, 5);
        check("onepop_full", longint'(fifo_full), 1);
        check("onepop_busy", longint'(busy), 1);
        check("onepop_grant", longint'(grant_id), 2);
        rd_rand = 1'b1;
        wait_idle(200, "full_drain");

        // Reset mid-burst after beat 3 of producer 0.
        do_reset(4096);
        chk_g = 1'b1;
        push_grant(0, 3, -1);
        push_grant(0, 5, 6);
        push_grant(1, 2, 3);
        n0 = nwrites;
        for (int i = 0; i < MB; i++) push_word(0, 32'h40 + i, 0);
        wait_writes(n0 + 3, 100, "midburst");
        #2;
        check("pre_reset_busy", longint'(busy), 1);
        reset = 1'b0;
        #1;
        check("async_ready", longint'(req_ready), 0);
        check("async_wenb", longint'(fifo_w_enb), 0);
        check("async_busy", longint'(busy), 0);
        push_word(1, 32'h50, 0);
        push_word(1, 32'h51, 0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        wait_idle(200, "reset_resume");

        // Fairness: producer 1 releases after 2 beats, producer 3 must go next.
        do_reset(4096);
        chk_g = 1'b1;
        push_grant(1, 2, 3);
        push_grant(3, 3, 4);
        push_grant(1, 2, 3);
        push_word(1, 32'hB0, 0);
        push_word(1, 32'hB1, 0);
        push_word(1, 32'hB2, 1);
        push_word(1, 32'hB3, 0);
        push_word(3, 32'hC0, 0);
        push_word(3, 32'hC1, 0);
        push_word(3, 32'hC2, 0);
        wait_idle(200, "fairness");

        // Data integrity: 1024 random words, random gaps, random reader on a small FIFO.
        do_reset(8);
        rd_rand = 1'b1;
        n0 = nwrites;
        for (int p = 0; p < N; p++) begin
            for (int i = 0; i < 256; i++) begin
                push_word(p, $urandom, ($urandom_range(0, 3) == 0) ? 1 : 0);
            end
        end
        wait_idle(30000, "random");
        check("random_writes", nwrites - n0, 1024);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
